// File: rtl/frv_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : frv_divider_if
//  Description : Request/response bundle between execute and the sequential
//                divider: operation select, operands, flush, and the
//                ready/result return path.
//  Revision    : 1.0 - initial release
// ============================================================================
interface frv_divider_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            valid;
    logic            op_div;
    logic            op_divu;
    logic            op_rem;
    logic            op_remu;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            ready;
    logic [XLEN-1:0] result;

    // Execute stage side: issues requests, consumes the result.
    modport master (
        output flush, valid, op_div, op_divu, op_rem, op_remu, rs1, rs2,
        input  ready, result
    );

    // Divider side.
    modport slave (
        input  flush, valid, op_div, op_divu, op_rem, op_remu, rs1, rs2,
        output ready, result
    );
endinterface
`default_nettype wire

// File: rtl/frv_divider.sv
`default_nettype none
// ============================================================================
//  Module      : frv_divider
//  Description : Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//                One quotient bit per cycle, 33-cycle latency, single-cycle
//                divide-by-zero path, registered result with a one-cycle
//                ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module frv_divider (
    input  wire logic    g_clk,
    input  wire logic    g_reset,
    frv_divider_if.slave bus
);

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_ready;

    logic [XLEN-1:0]   r_quot;
    // The partial remainder never exceeds the divisor after a step, so its
    // 33rd bit is always zero once stored; only 32 bits are kept.
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_dvs;
    logic [4:0]        r_count;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_is_rem;
    logic [XLEN-1:0]   r_result;

    logic              w_start;
    logic              w_signed;
    logic              w_rem;
    logic              w_div_zero;
    logic [XLEN-1:0]   w_rs1_mag;
    logic [XLEN-1:0]   w_rs2_mag;
    logic [XLEN:0]     w_partial;
    logic [XLEN:0]     w_trial;
    logic [XLEN-1:0]   w_quot_step;
    logic [XLEN-1:0]   w_acc_step;
    logic [XLEN-1:0]   w_q_final;
    logic [XLEN-1:0]   w_r_final;

    assign w_start    = bus.valid & (bus.op_div | bus.op_divu | bus.op_rem | bus.op_remu);
    assign w_signed   = bus.op_div | bus.op_rem;
    assign w_rem      = bus.op_rem | bus.op_remu;
    assign w_div_zero = (bus.rs2 == '0);

    // Magnitudes wrap at 32 bits, so 0x80000000 maps onto itself.
    assign w_rs1_mag  = (w_signed & bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
    assign w_rs2_mag  = (w_signed & bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;

    // One restoring step: shift in the next dividend bit, try to subtract.
    assign w_partial   = {r_acc, r_quot[XLEN-1]};
    assign w_trial     = w_partial - {1'b0, r_dvs};
    assign w_quot_step = {r_quot[XLEN-2:0], ~w_trial[XLEN]};
    assign w_acc_step  = w_trial[XLEN] ? w_partial[XLEN-1:0] : w_trial[XLEN-1:0];

    // Sign fix-up applied to the values produced by the final step.
    assign w_q_final = r_neg_q ? -w_quot_step : w_quot_step;
    assign w_r_final = r_neg_r ? -w_acc_step  : w_acc_step;

    // State register.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and ready decode; flush abandons work from any state.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        if (bus.flush) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        w_state_next = w_div_zero ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (r_count == 5'd0) begin
                        w_state_next = DONE;
                    end
                end
                DONE: begin
                    w_ready      = ~g_reset;
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // Operand latch, iteration, and result capture on entry to DONE.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_quot   <= '0;
            r_acc    <= '0;
            r_dvs    <= '0;
            r_count  <= 5'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
            r_result <= '0;
        end else if (!bus.flush) begin
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        if (w_div_zero) begin
                            r_result <= w_rem ? bus.rs1 : '1;
                        end else begin
                            r_quot   <= w_rs1_mag;
                            r_acc    <= '0;
                            r_dvs    <= w_rs2_mag;
                            r_count  <= 5'd31;
                            r_neg_q  <= w_signed & (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]);
                            r_neg_r  <= w_signed & bus.rs1[XLEN-1];
                            r_is_rem <= w_rem;
                        end
                    end
                end
                RUN: begin
                    r_quot  <= w_quot_step;
                    r_acc   <= w_acc_step;
                    r_count <= r_count - 5'd1;
                    if (r_count == 5'd0) begin
                        r_result <= r_is_rem ? w_r_final : w_q_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready  = w_ready;
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_frv_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_frv_divider
//  Description : Directed and randomised bench for frv_divider with a
//                scoreboard of expected results and completion cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frv_divider;

    localparam int OP_DIV  = 0;
    localparam int OP_DIVU = 1;
    localparam int OP_REM  = 2;
    localparam int OP_REMU = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frv_divider_if #(.XLEN(32)) bus ();

    frv_divider dut (
        .g_clk   (clk),
        .g_reset (rst),
        .bus     (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_result = 32'h0;

    typedef struct packed {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Independent reference built on the language's own division operators.
    function automatic logic [31:0] ref_model(input int op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        if (b == 32'h0) return (op == OP_REM || op == OP_REMU) ? a : 32'hFFFF_FFFF;
        case (op)
            OP_DIV: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sr = sa / sb;
                return sr;
            end
            OP_DIVU: return a / b;
            OP_REM: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sr = sa % sb;
                return sr;
            end
            default: return a % b;
        endcase
    endfunction

    // Scoreboard: every ready pulse must match the oldest outstanding entry.
    always @(negedge clk) begin
        if (bus.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_ready: observed ready=1 result=%h expected no completion", bus.result);
            end else begin
                exp_t  e;
                string t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check({t, "_result"}, bus.result, e.res);
                check({t, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int op, input logic [31:0] a, input logic [31:0] b);
        bus.op_div  = (op == OP_DIV);
        bus.op_divu = (op == OP_DIVU);
        bus.op_rem  = (op == OP_REM);
        bus.op_remu = (op == OP_REMU);
        bus.rs1     = a;
        bus.rs2     = b;
        bus.valid   = 1'b1;
    endtask

    task automatic clear_op();
        bus.valid   = 1'b0;
        bus.op_div  = 1'b0;
        bus.op_divu = 1'b0;
        bus.op_rem  = 1'b0;
        bus.op_remu = 1'b0;
    endtask

    // Issue one request in the current cycle, wait for its ready, drop valid,
    // then confirm ready lasted only one cycle.
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input string tag);
        int   lat;
        bit   seen;
        exp_t e;
        lat   = (b == 32'h0) ? 1 : 33;
        seen  = 1'b0;
        set_op(op, a, b);
        e.res = expv;
        e.cyc = cyc + lat;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        for (int i = 0; i < lat + 4 && !seen; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed ready=0 expected ready=1 within %0d cycles", tag, lat + 4);
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_back());
                void'(tag_q.pop_back());
            end
        end
        last_result = expv;
        next_cycle();
        clear_op();
        @(negedge clk);
        check({tag, "_ready_pulse"}, {31'b0, bus.ready}, 32'h0);
        next_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          op;
        logic [31:0] a;
        logic [31:0] b;

        bus.flush = 1'b0;
        bus.rs1   = 32'h0;
        bus.rs2   = 32'h0;
        clear_op();

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready",  {31'b0, bus.ready}, 32'h0);
        check("reset_result", bus.result, 32'h0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Basic unsigned and signed cases.
        run_op(OP_DIVU, 32'd100,       32'd7,         32'd14,         "divu_100_7");
        run_op(OP_REMU, 32'd100,       32'd7,         32'd2,          "remu_100_7");
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD,  "div_m7_2");
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF,  "rem_m7_2");
        run_op(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD,  "div_7_m2");
        run_op(OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,          "rem_7_m2");

        // Divide by zero completes the cycle after the request.
        run_op(OP_DIV,  32'h1234_5678, 32'h0,         32'hFFFF_FFFF,  "div_by_zero");
        run_op(OP_REMU, 32'h1234_5678, 32'h0,         32'h1234_5678,  "remu_by_zero");

        // Signed overflow and unsigned extremes.
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  "div_overflow");
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,          "rem_overflow");
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF,  "divu_max_1");
        run_op(OP_REMU, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF,  "remu_max_64k");
        run_op(OP_DIVU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0,          "divu_big_div");
        run_op(OP_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE,  "remu_big_div");

        // Randomised operands against the reference model.
        for (int i = 0; i < 8; i++) begin
            op = int'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i == 7) b = 32'hFFFF_FFFD;
            run_op(op, a, b, ref_model(op, a, b), "rand");
        end

        // Flush mid-operation: no ready, result held, next request normal.
        n = cyc;
        set_op(OP_DIVU, 32'd1000, 32'd3);
        while (cyc < n + 10) next_cycle();
        bus.flush = 1'b1;
        clear_op();
        next_cycle();
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_ready",       {31'b0, bus.ready}, 32'h0);
        check("flush_result_hold", bus.result, last_result);
        next_cycle();
        check("flush_restart_cycle", 32'(cyc), 32'(n + 12));
        run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, "divu_after_flush");

        // Reset mid-operation: outputs return to reset values, no completion.
        n = cyc;
        set_op(OP_DIVU, 32'd1000, 32'd7);
        while (cyc < n + 20) next_cycle();
        rst = 1'b1;
        clear_op();
        next_cycle();
        @(negedge clk);
        check("midreset_ready",  {31'b0, bus.ready}, 32'h0);
        check("midreset_result", bus.result, 32'h0);
        next_cycle();
        rst = 1'b0;
        repeat (40) next_cycle();
        @(negedge clk);
        check("post_reset_result", bus.result, 32'h0);
        next_cycle();
        run_op(OP_DIVU, 32'd50, 32'd5, 32'd10, "divu_after_reset");

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
